// File: rtl/i2s_tx.sv
// i2s_tx: stereo 16-bit Philips I2S transmitter.
// One sample pair is buffered in a holding register behind a valid/ready
// handshake; each frame is shifted out MSB-first with BCLK and LRCLK
// generated locally from clock_in.
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN adds a saturating
// underrun_count output that counts frames sent without fresh data.
module i2s_tx #(
    parameter int BCLK_DIV = 5
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        frame_strobe,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]  underrun_count
`endif
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [4:0]       next_bit;
    logic             div_wrap;
    logic             fall_event;
    logic             load;
    logic             accept;
    logic             hold_valid;
    logic [31:0]      hold_word;
    logic [31:0]      frame_word;
    logic [31:0]      load_word;

    // Fall events are the wrap cycles in which BCLK is currently high.
    assign div_wrap   = (div_cnt == DIV_LAST);
    assign fall_event = div_wrap && i2s_bclk;
    assign next_bit   = bit_cnt + 5'd1;
    assign load       = fall_event && (next_bit == 5'd0);

    // Hold is only writable while empty, so a full hold can never be
    // overwritten; an empty hold at load time repeats the previous word.
    assign sample_ready = !hold_valid;
    assign accept       = sample_valid && !hold_valid;
    assign load_word    = hold_valid ? hold_word : frame_word;

    // Bit clock divider: toggle BCLK every BCLK_DIV input clocks.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= !i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + DIV_ONE;
        end
    end

    // Bit position, word select, serial data and frame load on each BCLK fall.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            bit_cnt      <= 5'd31;
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            frame_strobe <= 1'b0;
            frame_word   <= '0;
        end else begin
            frame_strobe <= 1'b0;
            if (fall_event) begin
                bit_cnt   <= next_bit;
                // LRCLK leads the data by one bit: it switches at the LSB
                // of the previous word, ahead of each word's MSB.
                i2s_lrclk <= (next_bit >= 5'd15) && (next_bit <= 5'd30);
                if (load) begin
                    frame_word   <= load_word;
                    i2s_sdata    <= load_word[31];
                    frame_strobe <= 1'b1;
                end else begin
                    i2s_sdata    <= frame_word[5'd31 - next_bit];
                end
            end
        end
    end

    // Holding register: filled by the handshake, emptied by a frame load.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_word  <= '0;
        end else if (load && hold_valid) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_word  <= {sample_left, sample_right};
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating count of frames that repeated the previous word.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            underrun_count <= 8'd0;
        end else if (load && !hold_valid && (underrun_count != 8'hFF)) begin
            underrun_count <= underrun_count + 8'd1;
        end
    end
`endif

endmodule
